// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller.
// Holds the FSM state encoding, the default wait budget and the timeout fill value.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int unsigned  DEFAULT_MAX_WAIT = 15;
    localparam logic [15:0]  LDATA_TIMEOUT    = 16'h0000;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory stage.
// Counts BUSY cycles and flags the cycle whose increment reaches MAX_WAIT.
module mem_wait_timer
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_count;

    // Wait counter: clear has priority, otherwise count while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // Expiry fires in the cycle whose increment brings the count to MAX_WAIT.
    assign o_expired = i_en && (r_count == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns a single-cycle load/store into a req/ack
// bus transaction, stalls the pipeline until completion and bounds the wait.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_MEM,
    input  logic [15:0] wdata_MEM,
    input  logic        mem_re_MEM,
    input  logic        mem_we_MEM,
    output logic [15:0] ldata_MEM,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_req;
    logic        w_timeout;
    logic        w_op;
    logic        w_is_load;
    logic        w_expired;
    logic [15:0] r_ldata;
    logic        r_err;

    assign w_op      = mem_re_MEM | mem_we_MEM;
    assign w_is_load = mem_re_MEM & ~mem_we_MEM;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state != BUSY),
        .i_en      (r_state == BUSY),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and request/stall; an ack in the same cycle as expiry wins.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_op) begin
                    w_req       = 1'b1;
                    w_state_nxt = mem_ack ? DONE : BUSY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                w_req = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = DONE;
                end else if (w_expired) begin
                    w_state_nxt = DONE;
                    w_timeout   = 1'b1;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Load data register: captures read data on a load ack, zero on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ldata <= 16'h0000;
        end else if (w_timeout) begin
            r_ldata <= LDATA_TIMEOUT;
        end else if (w_req && mem_ack && w_is_load) begin
            r_ldata <= mem_rdata;
        end else begin
            r_ldata <= r_ldata;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign mem_req   = w_req;
    assign stall     = w_req;
    assign mem_wr    = mem_we_MEM;
    assign mem_addr  = addr_MEM;
    assign mem_wdata = wdata_MEM;
    assign ldata_MEM = r_ldata;
    assign err       = r_err;

endmodule
